// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants and types used by the fmul scheduler.
package fpu_pkg;
    localparam int FMUL_LATENCY = 3;
    localparam int TAG_IDW = 2;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;
    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first active request at or after ptr_i.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);
    always_comb begin
        int j;
        logic found;
        j = 0;
        found = 1'b0;
        grant_o = '0;
        idx_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o = IDW'(j);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fmul_rr_sched.sv
// fmul_rr_sched: shares one pipelined fmul between NREQ requesters, round-robin,
// carrying each requester id through a tag pipe that matches the fmul latency.
module fmul_rr_sched
    import fpu_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int FMUL_LATENCY = fpu_pkg::FMUL_LATENCY,
    parameter int IDW          = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_op1,
    input  logic [NREQ*32-1:0]   req_op2,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          fmul_op1,
    output logic [31:0]          fmul_op2,
    input  logic [31:0]          fmul_result,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_data,
    output logic                 busy,
    output logic [IDW+1:0]       inflight_cnt
);
    localparam int CW = IDW + 2;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_idx, ptr_q, ptr_d, last_id_q, last_id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hs;
    fp32_t           op1_q, op1_d, op2_q, op2_d;
    tag_t            tag_q [FMUL_LATENCY];
    tag_t            tail;
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx)
    );
    always_comb begin
        hs = |grant;
        tail = tag_q[FMUL_LATENCY-1];
        ptr_d = hs ? ((win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1) : ptr_q;
        op1_d = hs ? fp32_t'(req_op1[32*win_idx +: 32]) : op1_q;
        op2_d = hs ? fp32_t'(req_op2[32*win_idx +: 32]) : op2_q;
        cnt_d = cnt_q + CW'(hs) - CW'(tail.valid);
        last_id_d = tail.valid ? IDW'(tail.id) : last_id_q;
    end
    // Reset only needs to clear the valids, but clearing whole tags keeps state tidy.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
            cnt_q <= '0;
            last_id_q <= '0;
            for (int k = 0; k < FMUL_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            ptr_q <= ptr_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
            cnt_q <= cnt_d;
            last_id_q <= last_id_d;
            tag_q[0] <= '{valid: hs, id: TAG_IDW'(win_idx)};
            for (int k = 1; k < FMUL_LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end
    assign req_ready = grant;
    assign fmul_op1 = op1_q;
    assign fmul_op2 = op2_q;
    assign resp_valid = tail.valid;
    assign resp_id = tail.valid ? IDW'(tail.id) : last_id_q;
    assign resp_data = fmul_result;
    assign busy = cnt_q != '0;
    assign inflight_cnt = cnt_q;
endmodule

// File: tb/tb_fmul_rr_sched.sv
// tb_fmul_rr_sched: random and directed stimulus checked against a queue-based
// model of the scheduler, with a simple fp32 multiplier standing in for fmul.
module tb_fmul_rr_sched;
    localparam int N = 4;
    localparam int L = 3;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*32-1:0] req_op1 = '0, req_op2 = '0;
    logic [N-1:0]  req_ready;
    logic [31:0]   fmul_op1, fmul_op2, fmul_result, resp_data;
    logic          resp_valid, busy;
    logic [1:0]    resp_id;
    logic [3:0]    inflight_cnt;
    int n_chk = 0;
    int n_fail = 0;
    fmul_rr_sched #(.NREQ(N), .FMUL_LATENCY(L), .IDW(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
        .req_ready(req_ready), .fmul_op1(fmul_op1), .fmul_op2(fmul_op2), .fmul_result(fmul_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .busy(busy),
        .inflight_cnt(inflight_cnt)
    );
    always #5 clk = ~clk;
    // Normal-number fp32 multiply, truncating.
    function automatic logic [31:0] fmul_f(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [22:0] fr;
        int e;
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            fr = m[46:24];
            e++;
        end else fr = m[45:23];
        return {a[31] ^ b[31], 8'(e), fr};
    endfunction
    logic [31:0] p1, p2;
    always @(posedge clk) begin
        p1 <= fmul_f(fmul_op1, fmul_op2);
        p2 <= p1;
    end
    assign fmul_result = p2;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    typedef struct {
        int id;
        logic [31:0] a;
        logic [31:0] b;
        int due;
    } ent_t;
    ent_t q[$];
    int m_ptr = 0, last_id = 0, cyc_n = 0;
    logic [31:0] m_op1 = '0, m_op2 = '0;
    bit armed = 0;
    always @(negedge clk) begin
        int w;
        bit ev;
        logic [N-1:0] exp_ready;
        #2;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        exp_ready = (w < 0) ? '0 : N'(1 << w);
        ev = q.size() != 0 && q[0].due == cyc_n;
        if (armed) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            chk("resp_id", 32'(resp_id), ev ? q[0].id : last_id);
            if (ev) chk("resp_data", resp_data, fmul_f(q[0].a, q[0].b));
            chk("inflight_cnt", 32'(inflight_cnt), q.size());
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("fmul_op1", fmul_op1, m_op1);
            chk("fmul_op2", fmul_op2, m_op2);
        end
        if (reset) begin
            q.delete();
            m_ptr = 0;
            last_id = 0;
            m_op1 = '0;
            m_op2 = '0;
            armed = 1;
        end else if (armed) begin
            if (ev) begin
                last_id = q[0].id;
                void'(q.pop_front());
            end
            if (w >= 0) begin
                q.push_back('{w, req_op1[32*w +: 32], req_op2[32*w +: 32], cyc_n + L});
                m_op1 = req_op1[32*w +: 32];
                m_op2 = req_op2[32*w +: 32];
                m_ptr = (w + 1) % N;
            end
        end
        cyc_n++;
    end
    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction
    task automatic cyc(input logic [N-1:0] v);
        @(negedge clk);
        reset = 1'b0;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_op1[32*i +: 32] = rnd_fp();
            req_op2[32*i +: 32] = rnd_fp();
        end
    endtask
    task automatic rst_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            reset = 1'b1;
            req_valid = '0;
        end
    endtask
    task automatic idle(input int n);
        repeat (n) cyc('0);
    endtask
    int exp_cnt[7] = '{0, 1, 2, 3, 2, 1, 0};
    logic [N-1:0] g;
    initial begin
        rst_cycles(3);
        idle(10);
        #3;
        chk("idle_ready", 32'(req_ready), 0);
        chk("idle_resp_valid", 32'(resp_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_fmul_op1", fmul_op1, 0);
        cyc(4'b0010);
        req_op1[63:32] = 32'h3FC00000;
        req_op2[63:32] = 32'h40000000;
        #3;
        chk("req1_ready", 32'(req_ready), 32'b0010);
        idle(3);
        #3;
        chk("req1_resp_valid", 32'(resp_valid), 1);
        chk("req1_resp_id", 32'(resp_id), 1);
        chk("req1_resp_data", resp_data, 32'h40400000);
        idle(3);
        rst_cycles(1);
        for (int k = 0; k < 8; k++) begin
            cyc(4'hF);
            g = 4'b0001 << (k % 4);
            #3;
            chk("rotate_grant", 32'(req_ready), 32'(g));
        end
        idle(5);
        cyc(4'b0100);
        cyc(4'b1100);
        #3;
        chk("wrap_grant3", 32'(req_ready), 32'b1000);
        cyc(4'b1100);
        #3;
        chk("wrap_grant2", 32'(req_ready), 32'b0100);
        idle(6);
        for (int k = 0; k < 7; k++) begin
            cyc(k < 3 ? 4'hF : 4'h0);
            #3;
            chk("seq_inflight", 32'(inflight_cnt), exp_cnt[k]);
            if (k == 5) chk("seq_last_resp", 32'(resp_valid), 1);
            if (k == 6) chk("seq_busy_low", 32'(busy), 0);
        end
        cyc(4'hF);
        cyc(4'hF);
        rst_cycles(1);
        for (int k = 0; k < 5; k++) begin
            cyc('0);
            #3;
            chk("rst_no_resp", 32'(resp_valid), 0);
            chk("rst_inflight", 32'(inflight_cnt), 0);
        end
        cyc(4'hF);
        #3;
        chk("rst_ptr_grant", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 60) == 0) rst_cycles(1);
            else cyc(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
        end
        idle(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
